alphacore_scan_ctrl: RTL and testbench
======================================

// Module: alphacore_scan_ctrl
// PURPOSE
// - Automated register-scan sequencer for alphacore: replaces manual switch_select/switch_run toggling.
// - Walks a programmable slot table of register indices. For each slot it drives dbg_sel, waits DWELL cycles, and samples dbg_rdata.
// - Each sample is emitted as a {sel, data} record on a valid/ready stream.
// - After the last slot it pulses core_run for RUN_PULSE cycles (one core step), then optionally rescans.
// PARAMETERS
// - DATA_W     32  register data width (matches reg_read_data_1)
// - ADDR_W      5  register select width (matches switch_select)
// - NUM_SLOTS  18  slot-table depth, >=1; IDX_W = max(1, $clog2(NUM_SLOTS))
// - DWELL      10  settle cycles per slot before sampling, >=1
// - RUN_PULSE  16  core_run high time in cycles, >=1
// PORTS
// - fastclk     in   1       clock; all logic on posedge
// - reset       in   1       synchronous, active-high reset
// - start       in   1       1-cycle pulse: begin a scan frame (ignored while busy)
// - continuous  in   1       level; sampled at end of STEP: 1 = rescan, 0 = return to IDLE
// - cfg_we      in   1       slot-table write strobe
// - cfg_idx     in   IDX_W   slot index to write
// - cfg_sel     in   ADDR_W  register index stored in slot cfg_idx
// - dbg_sel     out  ADDR_W  to core switch_select
// - dbg_rdata   in   DATA_W  from core reg_read_data_1
// - core_run    out  1       to core switch_run
// - rec_valid   out  1       record valid
// - rec_ready   in   1       record accepted when valid & ready
// - rec_sel     out  ADDR_W  register index of the record
// - rec_data    out  DATA_W  sampled register value
// - rec_last    out  1       record is the last slot of the frame
// - busy        out  1       high in every state except IDLE
// - frame_cnt   out  16      completed frames; wraps 0xFFFF -> 0
// - cfg_err     out  1       1-cycle pulse: cfg_we while busy or cfg_idx >= NUM_SLOTS
// BEHAVIOUR
// - Reset:
//   - state=IDLE; slot[i]=i mod 2^ADDR_W.
//   - dbg_sel=0, core_run=0, rec_*=0, busy=0, frame_cnt=0, cfg_err=0.
// - FSM: IDLE -> SETTLE -> CAPTURE -> EMIT -> (SETTLE | STEP) -> (SETTLE | IDLE).
//   - IDLE: start=1 -> SETTLE, slot index i=0. Writes to the slot table are accepted only in IDLE.
//   - SETTLE: dbg_sel=slot[i] registered on entry; a counter runs DWELL cycles, then -> CAPTURE.
//   - CAPTURE: one cycle; rec_data<=dbg_rdata, rec_sel<=slot[i], rec_last<=(i==NUM_SLOTS-1); -> EMIT.
//   - EMIT: rec_valid=1, all rec_* held stable until rec_ready.
//     - On accept: rec_valid<=0 next cycle.
//     - If last slot -> STEP; else i++ -> SETTLE.
//     - rec_ready already high on the first EMIT cycle gives a 1-cycle EMIT.
//   - STEP: core_run=1 for exactly RUN_PULSE cycles, dbg_sel held. Then frame_cnt++ and core_run<=0.
//     - continuous=1 -> SETTLE with i=0 (no idle cycle); else -> IDLE.
// - Latency: start to first rec_valid = DWELL+2 cycles. Per-slot minimum = DWELL+2 cycles.
// - Backpressure: rec_ready low stalls in EMIT indefinitely. dbg_sel does not change; core_run stays 0.
// - Simultaneous events:
//   - start while busy is ignored.
//   - cfg_we together with start in IDLE: the write lands first, so the frame uses the new table.
//   - cfg_we while busy: no write, cfg_err pulse.
//   - continuous is sampled only on the last STEP cycle; changes elsewhere have no effect.
// - Reset mid-operation: immediate return to reset state (the slot table is also re-initialised).
//   - Any in-flight record is dropped; core_run falls the next cycle.
// CONFIGURATION
// - SCAN_CHANGE_ONLY_EN defined:
//   - A per-slot shadow register holds the last captured value.
//   - EMIT is skipped (CAPTURE -> next SETTLE/STEP directly) when the value equals the shadow and the frame is not the first since start.
//   - The last slot is always emitted so rec_last still marks the frame end.
//   - Shadows are cleared by reset and by start.
// - SCAN_CHANGE_ONLY_EN undefined: every slot is emitted each frame; no shadow storage.
// TESTING
// - Default table, NUM_SLOTS=18, DWELL=10, rec_ready=1, start pulse:
//   - 18 records, sel 0..17, rec_last only on sel=17.
//   - First rec_valid 12 cycles after start.
//   - Then core_run high exactly 16 cycles; frame_cnt=1; busy falls.
// - cfg writes in IDLE: slot0=16, slot1=24, NUM_SLOTS=2, dbg_rdata=sel*3:
//   - Records (16,48), (24,72).
//   - cfg_we during a scan -> cfg_err pulse, table unchanged.
// - rec_ready held low 50 cycles in EMIT of slot 3:
//   - rec_* stable, dbg_sel unchanged, core_run=0.
//   - On release the record is accepted once, with no duplicate.
// - continuous=1 for 3 frames, then dropped:
//   - frame_cnt=3; SETTLE follows STEP with no IDLE cycle between frames; IDLE after frame 3.
// - reset asserted mid-STEP, and mid-EMIT:
//   - Next cycle core_run=0, rec_valid=0, frame_cnt=0, table back to identity.
// - SCAN_CHANGE_ONLY_EN, constant dbg_rdata, continuous=1:
//   - Frame 1 emits all 18 records; frame 2 emits only the rec_last record.

Source files
------------

// File: rtl/alphacore_scan_ctrl.sv
// alphacore_scan_ctrl: automated register-scan sequencer for the alphacore debug port.
// Walks a programmable slot table of register indices. For each slot it drives
// dbg_sel, lets the read path settle for DWELL cycles, samples dbg_rdata and
// emits a {sel, data, last} record on a valid/ready stream. After the last slot
// it pulses core_run for RUN_PULSE cycles and then either rescans or idles.
// Optional build macro SCAN_CHANGE_ONLY_EN: suppress records whose value has
// not changed since the previous frame (the last slot is always emitted).
module alphacore_scan_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_SLOTS = 18,
    parameter int DWELL     = 10,
    parameter int RUN_PULSE = 16,
    parameter int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              fastclk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_sel,
    output logic [ADDR_W-1:0] dbg_sel,
    input  logic [DATA_W-1:0] dbg_rdata,
    output logic              core_run,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [ADDR_W-1:0] rec_sel,
    output logic [DATA_W-1:0] rec_data,
    output logic              rec_last,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic              cfg_err
);

    // One counter serves both the settle wait and the run pulse.
    localparam int CNT_MAX = (DWELL > RUN_PULSE) ? DWELL : RUN_PULSE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IDX_W:0] NUM_SLOTS_W = (IDX_W + 1)'(NUM_SLOTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_EMIT,
        S_STEP
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   dbg_sel_q;
    logic                core_run_q;
    logic                rec_valid_q;
    logic [ADDR_W-1:0]   rec_sel_q;
    logic [DATA_W-1:0]   rec_data_q;
    logic                rec_last_q;
    logic                busy_q;
    logic [15:0]         frame_cnt_q;
    logic                cfg_err_q;

    logic [ADDR_W-1:0]   slot_q [NUM_SLOTS];

    logic                cfg_idx_ok;
    logic                cfg_wr_en;
    logic                is_last;
    logic                skip_d;
    logic [ADDR_W-1:0]   slot_first_d;
    logic [ADDR_W-1:0]   slot_next_d;

    assign cfg_idx_ok = ({1'b0, cfg_idx} < NUM_SLOTS_W);
    assign cfg_wr_en  = cfg_we && cfg_idx_ok && (state_q == S_IDLE);
    assign is_last    = (idx_q == IDX_W'(NUM_SLOTS - 1));

    // A write coinciding with start must be visible to the very first slot,
    // so slot 0 is forwarded from the write port when it is being written.
    assign slot_first_d = (cfg_wr_en && (cfg_idx == '0)) ? cfg_sel : slot_q[0];
    assign slot_next_d  = is_last ? slot_q[0] : slot_q[idx_q + IDX_W'(1)];

    // Slot table: identity map after reset, writable only while idle.
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        always_ff @(posedge fastclk) begin
            if (reset) begin
                slot_q[gi] <= ADDR_W'(gi);
            end else if (cfg_wr_en && (cfg_idx == IDX_W'(gi))) begin
                slot_q[gi] <= cfg_sel;
            end
        end
    end

`ifdef SCAN_CHANGE_ONLY_EN
    logic                first_q;
    logic [DATA_W-1:0]   shadow_q [NUM_SLOTS];

    // Per-slot shadow of the last captured value; cleared at reset and start.
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_shadow
        always_ff @(posedge fastclk) begin
            if (reset) begin
                shadow_q[gi] <= '0;
            end else if ((state_q == S_IDLE) && start) begin
                shadow_q[gi] <= '0;
            end else if ((state_q == S_CAPTURE) && (idx_q == IDX_W'(gi))) begin
                shadow_q[gi] <= dbg_rdata;
            end
        end
    end

    // Unchanged values are dropped except in the first frame and on the last slot.
    assign skip_d = !first_q && !is_last && (dbg_rdata == shadow_q[idx_q]);
`else
    assign skip_d = 1'b0;
`endif

    // Scan sequencer: settle, capture, emit per slot, then the core step pulse.
    always_ff @(posedge fastclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            dbg_sel_q   <= '0;
            core_run_q  <= 1'b0;
            rec_valid_q <= 1'b0;
            rec_sel_q   <= '0;
            rec_data_q  <= '0;
            rec_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            cfg_err_q   <= 1'b0;
`ifdef SCAN_CHANGE_ONLY_EN
            first_q     <= 1'b0;
`endif
        end else begin
            cfg_err_q <= cfg_we && (!cfg_idx_ok || (state_q != S_IDLE));
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_SETTLE;
                        idx_q     <= '0;
                        cnt_q     <= '0;
                        dbg_sel_q <= slot_first_d;
                        busy_q    <= 1'b1;
`ifdef SCAN_CHANGE_ONLY_EN
                        first_q   <= 1'b1;
`endif
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == CNT_W'(DWELL - 1)) begin
                        state_q <= S_CAPTURE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (skip_d) begin
                        // Nothing new to report: move straight on to the next slot.
                        state_q   <= S_SETTLE;
                        idx_q     <= idx_q + IDX_W'(1);
                        dbg_sel_q <= slot_next_d;
                    end else begin
                        state_q     <= S_EMIT;
                        rec_valid_q <= 1'b1;
                        rec_sel_q   <= dbg_sel_q;
                        rec_data_q  <= dbg_rdata;
                        rec_last_q  <= is_last;
                    end
                end
                S_EMIT: begin
                    if (rec_ready) begin
                        rec_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        if (is_last) begin
                            state_q    <= S_STEP;
                            core_run_q <= 1'b1;
                        end else begin
                            state_q   <= S_SETTLE;
                            idx_q     <= idx_q + IDX_W'(1);
                            dbg_sel_q <= slot_next_d;
                        end
                    end
                end
                S_STEP: begin
                    if (cnt_q == CNT_W'(RUN_PULSE - 1)) begin
                        cnt_q       <= '0;
                        core_run_q  <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
`ifdef SCAN_CHANGE_ONLY_EN
                        first_q     <= 1'b0;
`endif
                        if (continuous) begin
                            state_q   <= S_SETTLE;
                            idx_q     <= '0;
                            dbg_sel_q <= slot_q[0];
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_sel   = dbg_sel_q;
    assign core_run  = core_run_q;
    assign rec_valid = rec_valid_q;
    assign rec_sel   = rec_sel_q;
    assign rec_data  = rec_data_q;
    assign rec_last  = rec_last_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_alphacore_scan_ctrl.sv
// Testbench for alphacore_scan_ctrl (default parameters: 18 slots, DWELL 10, RUN_PULSE 16).
// Expected records come from a frame-level model: table contents, the data
// function the bench drives on dbg_rdata, and the change-only rule when built
// with SCAN_CHANGE_ONLY_EN.
module tb_alphacore_scan_ctrl;

    localparam int NS  = 18;
    localparam int DWL = 10;
    localparam int RP  = 16;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int IW  = 5;
`ifdef SCAN_CHANGE_ONLY_EN
    localparam bit CO_EN = 1'b1;
`else
    localparam bit CO_EN = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [IW-1:0] idx;
        logic [AW-1:0] sel;
        logic          err;
    } cfg_vec_t;

    logic          fastclk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [AW-1:0] cfg_sel = '0;
    logic [AW-1:0] dbg_sel;
    logic [DW-1:0] dbg_rdata;
    logic          core_run;
    logic          rec_valid;
    logic          rec_ready = 1'b0;
    logic [AW-1:0] rec_sel;
    logic [DW-1:0] rec_data;
    logic          rec_last;
    logic          busy;
    logic [15:0]   frame_cnt;
    logic          cfg_err;

    // Bench-side "register file": value is a function of the selected index.
    logic [DW-1:0] rd_key = '0;
    logic          rd_const = 1'b0;
    assign dbg_rdata = rd_const ? rd_key : (32'(dbg_sel) * 32'd3 + rd_key);

    alphacore_scan_ctrl dut (
        .fastclk(fastclk), .reset(reset), .start(start), .continuous(continuous),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
        .dbg_sel(dbg_sel), .dbg_rdata(dbg_rdata), .core_run(core_run),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_sel(rec_sel),
        .rec_data(rec_data), .rec_last(rec_last), .busy(busy),
        .frame_cnt(frame_cnt), .cfg_err(cfg_err)
    );

    always #5 fastclk = ~fastclk;

    // rec_ready source: 0 = always ready, 1 = random, 2 = follow rdy_manual.
    int   rdy_mode = 0;
    logic rdy_manual = 1'b0;
    initial begin
        forever begin
            @(posedge fastclk);
            #2;
            case (rdy_mode)
                0:       rec_ready = 1'b1;
                1:       rec_ready = 1'($urandom_range(0, 1));
                default: rec_ready = rdy_manual;
            endcase
        end
    end

    // Monitor: accepted records and activity counters, sampled mid-cycle.
    logic [37:0] got_q [$];
    int          run_cycles = 0;
    int          busy_cycles = 0;
    always @(negedge fastclk) begin
        if (!reset) begin
            if (rec_valid && rec_ready) got_q.push_back({rec_last, rec_sel, rec_data});
            if (core_run) run_cycles++;
            if (busy) busy_cycles++;
        end
    end

    // Frame-level reference model.
    logic [AW-1:0] m_tbl [NS];
    logic [DW-1:0] m_shadow [NS];
    logic [37:0]   exp_q [$];
    int            exp_frames = 0;
    int            got_base = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) begin
            m_tbl[i]    = AW'(i);
            m_shadow[i] = '0;
        end
        exp_frames = 0;
    endfunction

    // Appends the records one frame should produce; returns how many.
    function automatic int model_frame(input bit first);
        int n = 0;
        logic [DW-1:0] d;
        bit last;
        bit emit;
        for (int i = 0; i < NS; i++) begin
            d    = rd_const ? rd_key : (32'(m_tbl[i]) * 32'd3 + rd_key);
            last = (i == NS - 1);
            emit = !CO_EN || first || last || (d != m_shadow[i]);
            m_shadow[i] = d;
            if (emit) begin
                exp_q.push_back({last, m_tbl[i], d});
                n++;
            end
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge fastclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic check_records(input string name);
        logic [37:0] g;
        chk({name, "_count"}, 64'(got_q.size() - got_base), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            g = (got_base + k < got_q.size()) ? got_q[got_base + k] : '1;
            chk($sformatf("%s_rec%0d", name, k), 64'(g), 64'(exp_q[k]));
            $display("%s rec %0d: sel=%0d data=0x%08h last=%0b", name, k, g[36:32], g[31:0], g[37]);
        end
        got_base = got_q.size();
        exp_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        cfg_vec_t    cv [6];
        int          t0_busy, t0_run, lat, n_emit, bad, n, base_fc;
        logic [37:0] snap;
        logic [AW-1:0] snap_sel;

        cv[0] = '{1'b1, 5'd0,  5'd16, 1'b0};
        cv[1] = '{1'b1, 5'd1,  5'd24, 1'b0};
        cv[2] = '{1'b1, 5'd18, 5'd7,  1'b1};
        cv[3] = '{1'b1, 5'd31, 5'd9,  1'b1};
        cv[4] = '{1'b0, 5'd20, 5'd3,  1'b0};
        cv[5] = '{1'b1, 5'd5,  5'd30, 1'b0};

        // ---- reset state
        model_reset();
        repeat (3) tick();
        chk("rst_dbg_sel", 64'(dbg_sel), 0);
        chk("rst_core_run", 64'(core_run), 0);
        chk("rst_rec_valid", 64'(rec_valid), 0);
        chk("rst_rec_sel", 64'(rec_sel), 0);
        chk("rst_rec_data", 64'(rec_data), 0);
        chk("rst_rec_last", 64'(rec_last), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_frame_cnt", 64'(frame_cnt), 0);
        chk("rst_cfg_err", 64'(cfg_err), 0);
        reset = 1'b0;
        tick();

        // ---- default table, always ready: latency, records, run pulse
        rd_key = $urandom;
        n_emit = model_frame(1'b1);
        exp_frames++;
        t0_busy = busy_cycles;
        t0_run  = run_cycles;
        pulse_start();
        lat = 1;
        while (!rec_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("first_valid_latency", 64'(lat), 64'(DWL + 2));
        wait_idle("dflt");
        check_records("dflt");
        chk("dflt_run_cycles", 64'(run_cycles - t0_run), 64'(RP));
        chk("dflt_busy_cycles", 64'(busy_cycles - t0_busy), 64'(NS * (DWL + 1) + n_emit + RP));
        chk("dflt_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

        // ---- table-driven slot-table writes in IDLE
        for (int k = 0; k < 6; k++) begin
            cfg_we = cv[k].we; cfg_idx = cv[k].idx; cfg_sel = cv[k].sel;
            tick();
            cfg_we = 1'b0;
            if (cv[k].we && (cv[k].idx < NS)) m_tbl[cv[k].idx] = cv[k].sel;
            chk($sformatf("cfg_vec%0d_err", k), 64'(cfg_err), 64'(cv[k].err));
            $display("cfg vec %0d: we=%0b idx=%0d sel=%0d cfg_err=%0b", k, cv[k].we, cv[k].idx, cv[k].sel, cfg_err);
        end

        // ---- frame with rec_ready random, data = sel*3; write and start while busy
        rd_key = '0;
        rdy_mode = 1;
        n_emit = model_frame(1'b1);
        exp_frames++;
        pulse_start();
        repeat (5) tick();
        cfg_we = 1'b1; cfg_idx = 5'd2; cfg_sel = 5'd29;
        tick();
        cfg_we = 1'b0;
        chk("busy_wr_err", 64'(cfg_err), 1);
        tick();
        chk("busy_wr_err_pulse", 64'(cfg_err), 0);
        pulse_start();
        wait_idle("rnd");
        check_records("rnd");
        chk("rnd_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

        // ---- write to slot 0 in the same cycle as start: frame uses new value
        rdy_mode = 0;
        rd_key = $urandom;
        cfg_we = 1'b1; cfg_idx = 5'd0; cfg_sel = 5'd9;
        start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        m_tbl[0] = 5'd9;
        n_emit = model_frame(1'b1);
        exp_frames++;
        chk("cfg_start_dbg_sel", 64'(dbg_sel), 9);
        chk("cfg_start_no_err", 64'(cfg_err), 0);
        wait_idle("cfgst");
        check_records("cfgst");

        // ---- backpressure: hold slot 3 for 50 cycles
        rdy_mode = 2;
        rdy_manual = 1'b0;
        rd_key = $urandom;
        n_emit = model_frame(1'b1);
        exp_frames++;
        pulse_start();
        for (int k = 0; k < NS; k++) begin
            n = 0;
            while (!rec_valid && n < 200) begin
                tick();
                n++;
            end
            if (!rec_valid) begin
                chk("bp_valid_timeout", 64'(rec_valid), 1);
                break;
            end
            if (k == 3) begin
                snap = {rec_last, rec_sel, rec_data};
                snap_sel = dbg_sel;
                bad = 0;
                repeat (50) begin
                    tick();
                    if (({rec_last, rec_sel, rec_data} !== snap) || (dbg_sel !== snap_sel) ||
                        (core_run !== 1'b0) || (rec_valid !== 1'b1)) bad++;
                end
                chk("bp_hold_violations", 64'(bad), 0);
            end else begin
                repeat ($urandom_range(0, 3)) tick();
            end
            rdy_manual = 1'b1;
            tick();
            rdy_manual = 1'b0;
            if (k == 3) chk("bp_single_accept", 64'(rec_valid), 0);
        end
        wait_idle("bp");
        check_records("bp");
        chk("bp_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        rdy_mode = 0;

        // ---- continuous for three frames
        rd_key = $urandom;
        continuous = 1'b1;
        t0_busy = busy_cycles;
        t0_run  = run_cycles;
        n_emit = model_frame(1'b1);
        n_emit += model_frame(1'b0);
        n_emit += model_frame(1'b0);
        exp_frames += 3;
        base_fc = int'(frame_cnt);
        pulse_start();
        n = 0;
        while ((frame_cnt != 16'(base_fc + 2)) && n < 3000) begin
            tick();
            n++;
        end
        chk("cont_two_frames", 64'(frame_cnt), 64'(base_fc + 2));
        chk("cont_no_idle", 64'(busy), 1);
        continuous = 1'b0;
        wait_idle("cont");
        check_records("cont");
        chk("cont_run_cycles", 64'(run_cycles - t0_run), 64'(3 * RP));
        chk("cont_busy_cycles", 64'(busy_cycles - t0_busy), 64'(3 * NS * (DWL + 1) + n_emit + 3 * RP));
        chk("cont_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

        // ---- reset during STEP
        pulse_start();
        n = 0;
        while (!core_run && n < 400) begin
            tick();
            n++;
        end
        chk("step_reached", 64'(core_run), 1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_step_core_run", 64'(core_run), 0);
        chk("rst_step_rec_valid", 64'(rec_valid), 0);
        chk("rst_step_frame_cnt", 64'(frame_cnt), 0);
        chk("rst_step_busy", 64'(busy), 0);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        got_base = got_q.size();

        // ---- reset during EMIT
        rdy_mode = 2;
        rdy_manual = 1'b0;
        pulse_start();
        n = 0;
        while (!rec_valid && n < 200) begin
            tick();
            n++;
        end
        chk("emit_reached", 64'(rec_valid), 1);
        reset = 1'b1;
        tick();
        chk("rst_emit_rec_valid", 64'(rec_valid), 0);
        chk("rst_emit_rec_data", 64'(rec_data), 0);
        chk("rst_emit_dbg_sel", 64'(dbg_sel), 0);
        chk("rst_emit_busy", 64'(busy), 0);
        reset = 1'b0;
        rdy_mode = 0;
        tick();
        got_base = got_q.size();

        // ---- table back to identity after reset
        rd_key = $urandom;
        n_emit = model_frame(1'b1);
        exp_frames++;
        pulse_start();
        wait_idle("ident");
        check_records("ident");
        chk("ident_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

`ifdef SCAN_CHANGE_ONLY_EN
        // ---- change-only: constant data, two continuous frames
        rd_const = 1'b1;
        rd_key = $urandom;
        continuous = 1'b1;
        n_emit = model_frame(1'b1);
        chk("co_frame1_model", 64'(n_emit), 64'(NS));
        n_emit = model_frame(1'b0);
        exp_frames += 2;
        base_fc = int'(frame_cnt);
        pulse_start();
        n = 0;
        while ((frame_cnt != 16'(base_fc + 1)) && n < 3000) begin
            tick();
            n++;
        end
        continuous = 1'b0;
        wait_idle("co");
        check_records("co");
        chk("co_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        rd_const = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
